// File: rtl/pc_hex_display.sv
// Debug display for the CPU program counter. It snapshots pcIn at a slow rate and
// scans the value in hex across a multiplexed, active-low seven-segment display.
module pc_hex_display #(
    parameter int DIGITS      = 8,
    parameter int REFRESH_DIV = 16384,
    parameter int BLANK_CYC   = 16,
    parameter int SAMPLE_DIV  = 1 << 22,
    parameter int DEBOUNCE    = 65536
) (
    input  logic              sysClk,
    input  logic              sysRes,
    input  logic [31:0]       pcIn,
    input  logic              btnFreeze,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [DIGITS-1:0] an,
    output logic              frozen
);

    localparam int IDX_W  = (DIGITS > 1)      ? $clog2(DIGITS)      : 1;
    localparam int SLOT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SAMP_W = (SAMPLE_DIV > 1)  ? $clog2(SAMPLE_DIV)  : 1;
    localparam int DEB_W  = (DEBOUNCE > 1)    ? $clog2(DEBOUNCE)    : 1;

    typedef enum logic [0:0] {
        PH_BLANK = 1'b0,
        PH_SHOW  = 1'b1
    } phase_t;

    logic              btn_meta_r;
    logic              btn_sync_r;
    logic              deb_last_r;
    logic              deb_level_r;
    logic [DEB_W-1:0]  deb_cnt_r;
    logic              frozen_r;
    logic [SAMP_W-1:0] sample_cnt_r;
    logic [31:0]       snap_r;
    logic [SLOT_W-1:0] slot_cnt_r;
    logic [IDX_W-1:0]  idx_r;
    logic [DIGITS-1:0] an_r;
    logic [6:0]        seg_r;
    logic              dp_r;
    phase_t            phase_s;
    logic [3:0]        nibble_s;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0:    hex_to_seg = 7'h40;
            4'h1:    hex_to_seg = 7'h79;
            4'h2:    hex_to_seg = 7'h24;
            4'h3:    hex_to_seg = 7'h30;
            4'h4:    hex_to_seg = 7'h19;
            4'h5:    hex_to_seg = 7'h12;
            4'h6:    hex_to_seg = 7'h02;
            4'h7:    hex_to_seg = 7'h78;
            4'h8:    hex_to_seg = 7'h00;
            4'h9:    hex_to_seg = 7'h10;
            4'hA:    hex_to_seg = 7'h08;
            4'hB:    hex_to_seg = 7'h03;
            4'hC:    hex_to_seg = 7'h46;
            4'hD:    hex_to_seg = 7'h21;
            4'hE:    hex_to_seg = 7'h06;
            4'hF:    hex_to_seg = 7'h0E;
            default: hex_to_seg = 7'h7F;
        endcase
    endfunction

    // Phase of the current slot and the nibble selected by the digit index.
    always_comb begin
        phase_s  = PH_SHOW;
        nibble_s = snap_r[4*int'(idx_r) +: 4];
        if (slot_cnt_r < SLOT_W'(BLANK_CYC)) begin
            phase_s = PH_BLANK;
        end else begin
            phase_s = PH_SHOW;
        end
    end

    // Synchronize and debounce the freeze button. An accepted rising edge toggles frozen.
    always_ff @(posedge sysClk or negedge sysRes) begin
        if (!sysRes) begin
            btn_meta_r  <= 1'b0;
            btn_sync_r  <= 1'b0;
            deb_last_r  <= 1'b0;
            deb_level_r <= 1'b0;
            deb_cnt_r   <= {DEB_W{1'b0}};
            frozen_r    <= 1'b0;
        end else begin
            btn_meta_r <= btnFreeze;
            btn_sync_r <= btn_meta_r;
            if (btn_sync_r != deb_last_r) begin
                deb_last_r <= btn_sync_r;
                deb_cnt_r  <= {DEB_W{1'b0}};
            end else if (deb_cnt_r == DEB_W'(DEBOUNCE - 1)) begin
                if (deb_last_r != deb_level_r) begin
                    deb_level_r <= deb_last_r;
                    if (deb_last_r) begin
                        frozen_r <= ~frozen_r;
                    end
                end
            end else begin
                deb_cnt_r <= deb_cnt_r + DEB_W'(1);
            end
        end
    end

    // Free-running sample divider. The snapshot loads on wrap unless frozen (pre-toggle value).
    always_ff @(posedge sysClk or negedge sysRes) begin
        if (!sysRes) begin
            sample_cnt_r <= {SAMP_W{1'b0}};
            snap_r       <= 32'h0000_0000;
        end else if (sample_cnt_r == SAMP_W'(SAMPLE_DIV - 1)) begin
            sample_cnt_r <= {SAMP_W{1'b0}};
            if (!frozen_r) begin
                snap_r <= pcIn;
            end
        end else begin
            sample_cnt_r <= sample_cnt_r + SAMP_W'(1);
        end
    end

    // Slot timer and digit index, wrapping DIGITS-1 -> 0.
    always_ff @(posedge sysClk or negedge sysRes) begin
        if (!sysRes) begin
            slot_cnt_r <= {SLOT_W{1'b0}};
            idx_r      <= {IDX_W{1'b0}};
        end else if (slot_cnt_r == SLOT_W'(REFRESH_DIV - 1)) begin
            slot_cnt_r <= {SLOT_W{1'b0}};
            if (idx_r == IDX_W'(DIGITS - 1)) begin
                idx_r <= {IDX_W{1'b0}};
            end else begin
                idx_r <= idx_r + IDX_W'(1);
            end
        end else begin
            slot_cnt_r <= slot_cnt_r + SLOT_W'(1);
        end
    end

    // Registered display drive: blank at slot start, then one anode with its hex digit.
    always_ff @(posedge sysClk or negedge sysRes) begin
        if (!sysRes) begin
            an_r  <= {DIGITS{1'b1}};
            seg_r <= 7'h7F;
            dp_r  <= 1'b1;
        end else begin
            case (phase_s)
                PH_BLANK: begin
                    an_r  <= {DIGITS{1'b1}};
                    seg_r <= 7'h7F;
                    dp_r  <= 1'b1;
                end
                PH_SHOW: begin
                    an_r  <= ~({{(DIGITS-1){1'b0}}, 1'b1} << idx_r);
                    seg_r <= hex_to_seg(nibble_s);
                    dp_r  <= ~(frozen_r && (idx_r == {IDX_W{1'b0}}));
                end
                default: begin
                    an_r  <= {DIGITS{1'b1}};
                    seg_r <= 7'h7F;
                    dp_r  <= 1'b1;
                end
            endcase
        end
    end

    assign an     = an_r;
    assign seg    = seg_r;
    assign dp     = dp_r;
    assign frozen = frozen_r;

endmodule

// File: tb/tb_pc_hex_display.sv
// Directed bench for pc_hex_display using small divider parameters so that a full
// scan, the sampling and the debounce each complete within a few dozen cycles.
module tb_pc_hex_display;

    logic        sysClk = 1'b0;
    logic        sysRes;
    logic [31:0] pcIn;
    logic        btnFreeze;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  an;
    logic        frozen;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    pc_hex_display #(
        .DIGITS(8), .REFRESH_DIV(4), .BLANK_CYC(1), .SAMPLE_DIV(8), .DEBOUNCE(3)
    ) dut (
        .sysClk(sysClk), .sysRes(sysRes), .pcIn(pcIn), .btnFreeze(btnFreeze),
        .seg(seg), .dp(dp), .an(an), .frozen(frozen)
    );

    always #5 sysClk = ~sysClk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] hex_seg(input logic [3:0] h);
        case (h)
            4'h0: hex_seg = 7'h40;  4'h1: hex_seg = 7'h79;
            4'h2: hex_seg = 7'h24;  4'h3: hex_seg = 7'h30;
            4'h4: hex_seg = 7'h19;  4'h5: hex_seg = 7'h12;
            4'h6: hex_seg = 7'h02;  4'h7: hex_seg = 7'h78;
            4'h8: hex_seg = 7'h00;  4'h9: hex_seg = 7'h10;
            4'hA: hex_seg = 7'h08;  4'hB: hex_seg = 7'h03;
            4'hC: hex_seg = 7'h46;  4'hD: hex_seg = 7'h21;
            4'hE: hex_seg = 7'h06;  4'hF: hex_seg = 7'h0E;
            default: hex_seg = 7'h7F;
        endcase
    endfunction

    task automatic tick();
        @(posedge sysClk);
        #1;
        cyc++;
    endtask

    // cyc counts edges since reset release; outputs after edge n show slot (n-1)%4 of digit ((n-1)/4)%8.
    task automatic check_scan(input int ncyc, input logic [31:0] pc, input logic frz);
        int          s;
        int          d;
        logic [31:0] sh;
        for (int k = 0; k < ncyc; k++) begin
            tick();
            s = (cyc - 1) % 4;
            d = ((cyc - 1) / 4) % 8;
            if (s == 0) begin
                check_val("blank_an", {24'd0, an}, 32'h0000_00FF);
                check_val("blank_seg", {25'd0, seg}, 32'h0000_007F);
                check_val("blank_dp", {31'd0, dp}, 32'd1);
            end else begin
                sh = pc >> (4 * d);
                check_val("show_an", {24'd0, an}, {24'd0, ~(8'd1 << d)});
                check_val("show_seg", {25'd0, seg}, {25'd0, hex_seg(sh[3:0])});
                check_val("show_dp", {31'd0, dp}, {31'd0, ~(frz && (d == 0))});
            end
            check_val("scan_frozen", {31'd0, frozen}, {31'd0, frz});
        end
    endtask

    // Anode and blanking invariants, sampled away from the active edge.
    always @(negedge sysClk) begin
        check_val("an_at_most_one_low", ($countones(~an) <= 1) ? 32'd1 : 32'd0, 32'd1);
        if (an == 8'hFF) begin
            check_val("seg_off_when_blank", {25'd0, seg}, 32'h0000_007F);
        end
    end

    initial begin
        int guard;
        sysRes    = 1'b0;
        pcIn      = 32'h0000_0000;
        btnFreeze = 1'b0;

        // Reset values.
        repeat (3) tick();
        check_val("rst_an", {24'd0, an}, 32'h0000_00FF);
        check_val("rst_seg", {25'd0, seg}, 32'h0000_007F);
        check_val("rst_dp", {31'd0, dp}, 32'd1);
        check_val("rst_frozen", {31'd0, frozen}, 32'd0);

        // Release; first cycle stays blank, then digit 0 shows snapshot 0.
        sysRes = 1'b1;
        pcIn   = 32'h0040_12AF;
        cyc    = 0;
        tick();
        check_val("release_an", {24'd0, an}, 32'h0000_00FF);
        check_val("release_seg", {25'd0, seg}, 32'h0000_007F);
        tick();
        check_val("first_show_an", {24'd0, an}, 32'h0000_00FE);
        check_val("first_show_seg", {25'd0, seg}, 32'h0000_0040);

        // Full scan of 0x004012AF including the 7 -> 0 wrap.
        while (cyc < 64) tick();
        check_scan(34, 32'h0040_12AF, 1'b0);
        check_val("wrap_an", {24'd0, an}, 32'h0000_00FE);
        check_val("wrap_seg", {25'd0, seg}, 32'h0000_000E);

        // One-cycle glitch is rejected.
        btnFreeze = 1'b1;
        tick();
        btnFreeze = 1'b0;
        repeat (8) tick();
        check_val("glitch_frozen", {31'd0, frozen}, 32'd0);

        // Held press freezes; dp lights only on digit 0.
        btnFreeze = 1'b1;
        repeat (10) tick();
        check_val("press_frozen", {31'd0, frozen}, 32'd1);
        check_scan(32, 32'h0040_12AF, 1'b1);

        // Frozen display ignores a new PC.
        pcIn = 32'hDEAD_BEEF;
        check_scan(40, 32'h0040_12AF, 1'b1);
        btnFreeze = 1'b0;
        repeat (8) tick();
        check_val("release_keeps_frozen", {31'd0, frozen}, 32'd1);
        btnFreeze = 1'b1;
        repeat (8) tick();
        check_val("second_press_unfrozen", {31'd0, frozen}, 32'd0);
        btnFreeze = 1'b0;
        repeat (8) tick();
        check_scan(32, 32'hDEAD_BEEF, 1'b0);

        // Reset asserted while digit 5 is shown.
        guard = 0;
        while (!((((cyc - 1) % 4) != 0) && ((((cyc - 1) / 4) % 8) == 5)) && guard < 64) begin
            tick();
            guard++;
        end
        check_val("pre_reset_digit5_an", {24'd0, an}, 32'h0000_00DF);
        #2;
        sysRes = 1'b0;
        #1;
        check_val("midrst_an", {24'd0, an}, 32'h0000_00FF);
        check_val("midrst_seg", {25'd0, seg}, 32'h0000_007F);
        check_val("midrst_dp", {31'd0, dp}, 32'd1);
        check_val("midrst_frozen", {31'd0, frozen}, 32'd0);
        repeat (2) tick();
        sysRes = 1'b1;
        cyc    = 0;
        check_scan(7, 32'h0000_0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
